// File: rtl/axc_adder_seq_if.sv
// AXI4-Lite master bus bundle used between axc_adder_seq and the adder peripheral.
// Ports: AW/W/B write channels and AR/R read channels, with master and slave views.
interface axc_adder_seq_if #(
    parameter int unsigned ADDR_W = 32
) ();

    logic [ADDR_W-1:0] M_AXI_AWADDR;
    logic [2:0]        M_AXI_AWPROT;
    logic              M_AXI_AWVALID;
    logic              M_AXI_AWREADY;

    logic [31:0]       M_AXI_WDATA;
    logic [3:0]        M_AXI_WSTRB;
    logic              M_AXI_WVALID;
    logic              M_AXI_WREADY;

    logic [1:0]        M_AXI_BRESP;
    logic              M_AXI_BVALID;
    logic              M_AXI_BREADY;

    logic [ADDR_W-1:0] M_AXI_ARADDR;
    logic [2:0]        M_AXI_ARPROT;
    logic              M_AXI_ARVALID;
    logic              M_AXI_ARREADY;

    logic [31:0]       M_AXI_RDATA;
    logic [1:0]        M_AXI_RRESP;
    logic              M_AXI_RVALID;
    logic              M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );

endinterface

// File: rtl/axc_adder_seq.sv
// AXI4-Lite master sequencer for an approximate-adder peripheral.
// For each accepted operand pair: write A, write B, read the sum, present it on
// the result stream with an error flag accumulated from BRESP/RRESP.
// Ports:
//   ACLK, ARESETN          clock, async active-low reset
//   op_valid/op_ready      operand handshake, op_a/op_b sampled on it
//   res_valid/res_ready    result handshake, res_data/res_err held until it
//   busy                   high outside IDLE
//   done_cnt               completed result handshakes, wrapping
//   m_axi                  AXI4-Lite master bus
module axc_adder_seq #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter logic [31:0] C_BASE_ADDR        = 32'h0000_0000,
    parameter logic [3:0]  C_OPA_OFFSET       = 4'h0,
    parameter logic [3:0]  C_OPB_OFFSET       = 4'h4,
    parameter logic [3:0]  C_RES_OFFSET       = 4'h8
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [31:0]           op_a,
    input  logic [31:0]           op_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [31:0]           res_data,
    output logic                  res_err,
    output logic                  busy,
    output logic [15:0]           done_cnt,
    axc_adder_seq_if.master       m_axi
);

    localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    localparam logic [AW-1:0] OPA_ADDR = AW'(C_BASE_ADDR) + AW'(C_OPA_OFFSET);
    localparam logic [AW-1:0] OPB_ADDR = AW'(C_BASE_ADDR) + AW'(C_OPB_OFFSET);
    localparam logic [AW-1:0] RES_ADDR = AW'(C_BASE_ADDR) + AW'(C_RES_OFFSET);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_A,
        S_WB_A,
        S_WR_B,
        S_WB_B,
        S_RD_ADDR,
        S_RD_DATA,
        S_OUT
    } state_t;

    state_t          r_state, w_state_nxt;

    logic            r_awvalid, w_awvalid_nxt;
    logic            r_wvalid,  w_wvalid_nxt;
    logic [AW-1:0]   r_awaddr,  w_awaddr_nxt;
    logic [DW-1:0]   r_wdata,   w_wdata_nxt;
    logic            r_bready,  w_bready_nxt;
    logic            r_arvalid, w_arvalid_nxt;
    logic [AW-1:0]   r_araddr,  w_araddr_nxt;
    logic            r_rready,  w_rready_nxt;
    logic            r_res_valid, w_res_valid_nxt;
    logic [DW-1:0]   r_res_data,  w_res_data_nxt;
    logic            r_res_err,   w_res_err_nxt;
    logic            r_err_acc,   w_err_acc_nxt;
    logic [DW-1:0]   r_opb,       w_opb_nxt;
    logic [CW-1:0]   r_done_cnt,  w_done_cnt_nxt;
    logic            r_busy,      w_busy_nxt;

    logic            w_wr_done;
    logic            w_bresp_err;
    logic            w_rresp_err;

    // Both write channels finished once each VALID is low or handshaking now.
    assign w_wr_done   = (!r_awvalid || m_axi.M_AXI_AWREADY) &&
                         (!r_wvalid  || m_axi.M_AXI_WREADY);
    // SLVERR and DECERR both have bit 1 set.
    assign w_bresp_err = m_axi.M_AXI_BRESP inside {2'b10, 2'b11};
    assign w_rresp_err = m_axi.M_AXI_RRESP inside {2'b10, 2'b11};

    // State and registered-output update.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state     <= S_IDLE;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_awaddr    <= '0;
            r_wdata     <= '0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_araddr    <= '0;
            r_rready    <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_err   <= 1'b0;
            r_err_acc   <= 1'b0;
            r_opb       <= '0;
            r_done_cnt  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_awvalid   <= w_awvalid_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_awaddr    <= w_awaddr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_bready    <= w_bready_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_araddr    <= w_araddr_nxt;
            r_rready    <= w_rready_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_res_data  <= w_res_data_nxt;
            r_res_err   <= w_res_err_nxt;
            r_err_acc   <= w_err_acc_nxt;
            r_opb       <= w_opb_nxt;
            r_done_cnt  <= w_done_cnt_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_awvalid_nxt   = r_awvalid;
        w_wvalid_nxt    = r_wvalid;
        w_awaddr_nxt    = r_awaddr;
        w_wdata_nxt     = r_wdata;
        w_bready_nxt    = r_bready;
        w_arvalid_nxt   = r_arvalid;
        w_araddr_nxt    = r_araddr;
        w_rready_nxt    = r_rready;
        w_res_valid_nxt = r_res_valid;
        w_res_data_nxt  = r_res_data;
        w_res_err_nxt   = r_res_err;
        w_err_acc_nxt   = r_err_acc;
        w_opb_nxt       = r_opb;
        w_done_cnt_nxt  = r_done_cnt;
        w_busy_nxt      = r_busy;

        case (r_state)
            S_IDLE: begin
                if (op_valid) begin
                    w_opb_nxt     = op_b;
                    w_err_acc_nxt = 1'b0;
                    w_awvalid_nxt = 1'b1;
                    w_wvalid_nxt  = 1'b1;
                    w_awaddr_nxt  = OPA_ADDR;
                    w_wdata_nxt   = op_a;
                    w_state_nxt   = S_WR_A;
                end
            end

            S_WR_A, S_WR_B: begin
                // Each VALID drops on its own handshake and is never re-raised.
                w_awvalid_nxt = r_awvalid && !m_axi.M_AXI_AWREADY;
                w_wvalid_nxt  = r_wvalid  && !m_axi.M_AXI_WREADY;
                if (w_wr_done) begin
                    w_bready_nxt = 1'b1;
                    w_state_nxt  = (r_state == S_WR_A) ? S_WB_A : S_WB_B;
                end
            end

            S_WB_A: begin
                if (m_axi.M_AXI_BVALID) begin
                    w_err_acc_nxt = r_err_acc | w_bresp_err;
                    w_bready_nxt  = 1'b0;
                    w_awvalid_nxt = 1'b1;
                    w_wvalid_nxt  = 1'b1;
                    w_awaddr_nxt  = OPB_ADDR;
                    w_wdata_nxt   = r_opb;
                    w_state_nxt   = S_WR_B;
                end
            end

            S_WB_B: begin
                if (m_axi.M_AXI_BVALID) begin
                    w_err_acc_nxt = r_err_acc | w_bresp_err;
                    w_bready_nxt  = 1'b0;
                    w_arvalid_nxt = 1'b1;
                    w_araddr_nxt  = RES_ADDR;
                    w_state_nxt   = S_RD_ADDR;
                end
            end

            S_RD_ADDR: begin
                if (m_axi.M_AXI_ARREADY) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = S_RD_DATA;
                end
            end

            S_RD_DATA: begin
                if (m_axi.M_AXI_RVALID) begin
                    w_rready_nxt    = 1'b0;
                    w_res_data_nxt  = m_axi.M_AXI_RDATA;
                    w_res_err_nxt   = r_err_acc | w_rresp_err;
                    w_err_acc_nxt   = r_err_acc | w_rresp_err;
                    w_res_valid_nxt = 1'b1;
                    w_state_nxt     = S_OUT;
                end
            end

            S_OUT: begin
                if (res_ready) begin
                    w_res_valid_nxt = 1'b0;
                    w_done_cnt_nxt  = r_done_cnt + CW'(1);
                    w_state_nxt     = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign op_ready  = (r_state == S_IDLE);
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_err   = r_res_err;
    assign busy      = r_busy;
    assign done_cnt  = r_done_cnt;

    assign m_axi.M_AXI_AWADDR  = r_awaddr;
    assign m_axi.M_AXI_AWPROT  = 3'b000;
    assign m_axi.M_AXI_AWVALID = r_awvalid;
    assign m_axi.M_AXI_WDATA   = r_wdata;
    assign m_axi.M_AXI_WSTRB   = 4'hF;
    assign m_axi.M_AXI_WVALID  = r_wvalid;
    assign m_axi.M_AXI_BREADY  = r_bready;
    assign m_axi.M_AXI_ARADDR  = r_araddr;
    assign m_axi.M_AXI_ARPROT  = 3'b000;
    assign m_axi.M_AXI_ARVALID = r_arvalid;
    assign m_axi.M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axc_adder_seq.sv
// Self-checking bench for axc_adder_seq with a register-backed adder slave model.
`timescale 1ns/1ps
module tb_axc_adder_seq;

    localparam int unsigned AW = 32;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] res_data;
    logic        res_err;
    logic        busy;
    logic [15:0] done_cnt;

    always #5 ACLK = ~ACLK;

    axc_adder_seq_if #(.ADDR_W(AW)) axi ();

    axc_adder_seq #(
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_BASE_ADDR       (32'h0000_0000),
        .C_OPA_OFFSET      (4'h0),
        .C_OPB_OFFSET      (4'h4),
        .C_RES_OFFSET      (4'h8)
    ) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err),
        .busy      (busy),
        .done_cnt  (done_cnt),
        .m_axi     (axi)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t        sb[$];
    logic [15:0] exp_done = '0;

    // ---------------- slave model ----------------
    int unsigned aw_dly = 0;
    int unsigned w_dly  = 0;
    logic        bresp_err_b = 1'b0;
    int unsigned aw_cnt, w_cnt;
    logic        aw_seen, w_seen;
    logic [31:0] aw_addr_q, w_data_q, reg_a, reg_b;
    int unsigned aw_hs_cnt = 0, w_hs_cnt = 0, ar_hs_cnt = 0, strb_bad = 0;
    logic [31:0] addr_log[$];
    logic [31:0] ar_log[$];
    logic        s_aw_hs, s_w_hs, s_got_aw, s_got_w;
    logic [31:0] s_addr, s_data;

    assign axi.M_AXI_AWREADY = (aw_cnt >= aw_dly);
    assign axi.M_AXI_WREADY  = (w_cnt >= w_dly);
    assign axi.M_AXI_ARREADY = 1'b1;

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_cnt <= 0;
            w_cnt <= 0;
            aw_seen <= 1'b0;
            w_seen <= 1'b0;
            axi.M_AXI_BVALID <= 1'b0;
            axi.M_AXI_BRESP <= 2'b00;
            axi.M_AXI_RVALID <= 1'b0;
            axi.M_AXI_RDATA <= '0;
            axi.M_AXI_RRESP <= 2'b00;
        end else begin
            s_aw_hs = axi.M_AXI_AWVALID && axi.M_AXI_AWREADY;
            s_w_hs  = axi.M_AXI_WVALID && axi.M_AXI_WREADY;
            aw_cnt <= (axi.M_AXI_AWVALID && !axi.M_AXI_AWREADY) ? aw_cnt + 1 : 0;
            w_cnt  <= (axi.M_AXI_WVALID && !axi.M_AXI_WREADY) ? w_cnt + 1 : 0;
            if (s_aw_hs) begin
                aw_hs_cnt <= aw_hs_cnt + 1;
                addr_log.push_back(axi.M_AXI_AWADDR);
            end
            if (s_w_hs) begin
                w_hs_cnt <= w_hs_cnt + 1;
                if (axi.M_AXI_WSTRB !== 4'hF) strb_bad <= strb_bad + 1;
            end
            s_got_aw = aw_seen || s_aw_hs;
            s_got_w  = w_seen || s_w_hs;
            s_addr   = s_aw_hs ? axi.M_AXI_AWADDR : aw_addr_q;
            s_data   = s_w_hs ? axi.M_AXI_WDATA : w_data_q;
            if (axi.M_AXI_BVALID && axi.M_AXI_BREADY) axi.M_AXI_BVALID <= 1'b0;
            if (s_got_aw && s_got_w) begin
                if (s_addr == 32'h0) reg_a <= s_data;
                else if (s_addr == 32'h4) reg_b <= s_data;
                axi.M_AXI_BVALID <= 1'b1;
                axi.M_AXI_BRESP  <= (bresp_err_b && s_addr == 32'h4) ? 2'b10 : 2'b00;
                aw_seen <= 1'b0;
                w_seen  <= 1'b0;
            end else begin
                aw_seen <= s_got_aw;
                w_seen  <= s_got_w;
                if (s_aw_hs) aw_addr_q <= axi.M_AXI_AWADDR;
                if (s_w_hs)  w_data_q  <= axi.M_AXI_WDATA;
            end
            if (axi.M_AXI_RVALID && axi.M_AXI_RREADY) axi.M_AXI_RVALID <= 1'b0;
            if (axi.M_AXI_ARVALID && axi.M_AXI_ARREADY) begin
                ar_hs_cnt <= ar_hs_cnt + 1;
                ar_log.push_back(axi.M_AXI_ARADDR);
                axi.M_AXI_RVALID <= 1'b1;
                axi.M_AXI_RDATA  <= reg_a + reg_b;
                axi.M_AXI_RRESP  <= 2'b00;
            end
        end
    end

    // ---------------- VALID/payload stability monitor ----------------
    int unsigned stab_bad = 0;
    logic        aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
    logic [31:0] aw_pend_addr, w_pend_data, ar_pend_addr;

    always @(posedge ACLK) begin
        if (ARESETN) begin
            if (aw_pend && (!axi.M_AXI_AWVALID || axi.M_AXI_AWADDR !== aw_pend_addr)) stab_bad++;
            if (w_pend && (!axi.M_AXI_WVALID || axi.M_AXI_WDATA !== w_pend_data)) stab_bad++;
            if (ar_pend && (!axi.M_AXI_ARVALID || axi.M_AXI_ARADDR !== ar_pend_addr)) stab_bad++;
        end
        aw_pend      = ARESETN && axi.M_AXI_AWVALID && !axi.M_AXI_AWREADY;
        w_pend       = ARESETN && axi.M_AXI_WVALID && !axi.M_AXI_WREADY;
        ar_pend      = ARESETN && axi.M_AXI_ARVALID && !axi.M_AXI_ARREADY;
        aw_pend_addr = axi.M_AXI_AWADDR;
        w_pend_data  = axi.M_AXI_WDATA;
        ar_pend_addr = axi.M_AXI_ARADDR;
    end

    // ---------------- stimulus / result tasks ----------------
    task automatic send_op(input logic [31:0] a, input logic [31:0] b, input logic e);
        int unsigned t;
        exp_t x;
        @(negedge ACLK);
        op_a = a;
        op_b = b;
        op_valid = 1'b1;
        t = 0;
        while (!op_ready && t < 50) begin
            @(negedge ACLK);
            t++;
        end
        n_vec++;
        if (!op_ready) begin
            n_err++;
            $display("FAIL op_accept: op_ready=%b required 1", op_ready);
            op_valid = 1'b0;
        end else begin
            @(posedge ACLK);
            #1 op_valid = 1'b0;
            x.data = a + b;
            x.err  = e;
            sb.push_back(x);
        end
    endtask

    task automatic wait_result(output int unsigned lat);
        exp_t x;
        lat = 0;
        while (!res_valid && lat < 200) begin
            @(negedge ACLK);
            lat++;
        end
        n_vec++;
        if (!res_valid) begin
            n_err++;
            $display("FAIL res_timeout: res_valid=%b required 1 within 200 cycles", res_valid);
        end else if (sb.size() == 0) begin
            n_err++;
            $display("FAIL res_unexpected: res_data=%h with empty scoreboard", res_data);
        end else begin
            x = sb.pop_front();
            if (res_data !== x.data) begin
                n_err++;
                $display("FAIL res_data: got %h required %h", res_data, x.data);
            end
            n_vec++;
            if (res_err !== x.err) begin
                n_err++;
                $display("FAIL res_err: got %b required %b", res_err, x.err);
            end
        end
    endtask

    task automatic accept_result();
        res_ready = 1'b1;
        @(posedge ACLK);
        #1;
        exp_done = exp_done + 16'd1;
        n_vec++;
        if (done_cnt !== exp_done || res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL res_accept: done_cnt=%0d res_valid=%b required %0d/0", done_cnt, res_valid, exp_done);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        ARESETN = 1'b0;
        repeat (3) @(negedge ACLK);
        n_vec++;
        if (axi.M_AXI_AWVALID || axi.M_AXI_WVALID || axi.M_AXI_ARVALID ||
            axi.M_AXI_BREADY || axi.M_AXI_RREADY || res_valid || busy) begin
            n_err++;
            $display("FAIL reset_handshake: aw=%b w=%b ar=%b b=%b r=%b rv=%b busy=%b required all 0",
                     axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_ARVALID,
                     axi.M_AXI_BREADY, axi.M_AXI_RREADY, res_valid, busy);
        end
        n_vec++;
        if (res_data !== 32'h0 || res_err !== 1'b0 || done_cnt !== 16'h0 ||
            axi.M_AXI_AWADDR !== 32'h0 || axi.M_AXI_ARADDR !== 32'h0 || axi.M_AXI_WDATA !== 32'h0) begin
            n_err++;
            $display("FAIL reset_data: res_data=%h err=%b done=%0d awaddr=%h araddr=%h wdata=%h required zeros",
                     res_data, res_err, done_cnt, axi.M_AXI_AWADDR, axi.M_AXI_ARADDR, axi.M_AXI_WDATA);
        end
        ARESETN = 1'b1;
        @(negedge ACLK);
        n_vec++;
        if (op_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_op_ready: got %b required 1", op_ready);
        end
    endtask

    task automatic test_basic();
        int unsigned lat;
        int unsigned a0, r0;
        a0 = addr_log.size();
        r0 = ar_log.size();
        send_op(32'h1, 32'h2, 1'b0);
        wait_result(lat);
        n_vec++;
        if (lat != 7) begin
            n_err++;
            $display("FAIL basic_latency: got %0d required 7", lat);
        end
        n_vec++;
        if (addr_log.size() != a0 + 2 || ar_log.size() != r0 + 1 ||
            addr_log[a0] !== 32'h0 || addr_log[a0+1] !== 32'h4 || ar_log[r0] !== 32'h8) begin
            n_err++;
            $display("FAIL basic_addr: %0d writes %0d reads, required writes 0,4 then read 8",
                     addr_log.size() - a0, ar_log.size() - r0);
        end
        accept_result();
        n_vec++;
        if (op_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_next_ready: op_ready=%b busy=%b required 1/0", op_ready, busy);
        end
    endtask

    task automatic test_wrap();
        int unsigned lat;
        int unsigned s0, aw0;
        s0  = strb_bad;
        aw0 = aw_hs_cnt;
        send_op(32'hFFFF_FFFF, 32'h1, 1'b0);
        wait_result(lat);
        accept_result();
        n_vec++;
        if (strb_bad != s0 || aw_hs_cnt != aw0 + 2) begin
            n_err++;
            $display("FAIL wrap_wstrb: bad strobes %0d writes %0d required 0 / 2",
                     strb_bad - s0, aw_hs_cnt - aw0);
        end
    endtask

    task automatic test_stalls();
        int unsigned lat, aw0, w0, st0, mx;
        int unsigned dly_aw[3] = '{0, 2, 2};
        int unsigned dly_w[3]  = '{3, 0, 2};
        for (int k = 0; k < 3; k++) begin
            aw_dly = dly_aw[k];
            w_dly  = dly_w[k];
            mx = (dly_aw[k] > dly_w[k]) ? dly_aw[k] : dly_w[k];
            aw0 = aw_hs_cnt;
            w0  = w_hs_cnt;
            st0 = stab_bad;
            send_op(32'd5, 32'd7, 1'b0);
            wait_result(lat);
            n_vec++;
            if (lat != 7 + 2 * mx) begin
                n_err++;
                $display("FAIL stall%0d_latency: got %0d required %0d", k, lat, 7 + 2 * mx);
            end
            accept_result();
            n_vec++;
            if (aw_hs_cnt != aw0 + 2 || w_hs_cnt != w0 + 2 || stab_bad != st0) begin
                n_err++;
                $display("FAIL stall%0d_channels: aw=%0d w=%0d unstable=%0d required 2/2/0",
                         k, aw_hs_cnt - aw0, w_hs_cnt - w0, stab_bad - st0);
            end
        end
        aw_dly = 0;
        w_dly  = 0;
    endtask

    task automatic test_bresp_err();
        int unsigned lat, ar0;
        ar0 = ar_hs_cnt;
        bresp_err_b = 1'b1;
        send_op(32'd3, 32'd4, 1'b1);
        wait_result(lat);
        accept_result();
        bresp_err_b = 1'b0;
        n_vec++;
        if (ar_hs_cnt != ar0 + 1) begin
            n_err++;
            $display("FAIL bresp_read: reads %0d required 1", ar_hs_cnt - ar0);
        end
        send_op(32'd9, 32'd10, 1'b0);
        wait_result(lat);
        accept_result();
    endtask

    task automatic test_backpressure();
        int unsigned lat, bad;
        logic [31:0] d;
        res_ready = 1'b0;
        send_op(32'h10, 32'h20, 1'b0);
        wait_result(lat);
        d = res_data;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            if (res_valid !== 1'b1 || res_data !== d || op_ready !== 1'b0 || done_cnt !== exp_done) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL backpressure_hold: %0d unstable cycles required 0 (res_data=%h op_ready=%b)",
                     bad, res_data, op_ready);
        end
        accept_result();
        repeat (3) @(negedge ACLK);
        n_vec++;
        if (done_cnt !== exp_done) begin
            n_err++;
            $display("FAIL backpressure_count: done_cnt=%0d required %0d", done_cnt, exp_done);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned lat;
        for (int i = 0; i < 4; i++) begin
            send_op(32'($urandom), 32'($urandom), 1'b0);
            wait_result(lat);
            accept_result();
        end
    endtask

    task automatic test_reset_mid();
        int unsigned lat;
        send_op(32'h11, 32'h22, 1'b0);
        repeat (4) @(negedge ACLK);
        n_vec++;
        if (axi.M_AXI_BREADY !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_state: bready=%b busy=%b required 1/1", axi.M_AXI_BREADY, busy);
        end
        ARESETN = 1'b0;
        #1;
        void'(sb.pop_back());
        exp_done = '0;
        n_vec++;
        if (axi.M_AXI_AWVALID || axi.M_AXI_WVALID || axi.M_AXI_ARVALID || res_valid ||
            axi.M_AXI_BREADY || busy || done_cnt !== 16'h0) begin
            n_err++;
            $display("FAIL midreset_async: aw=%b w=%b ar=%b rv=%b b=%b busy=%b done=%0d required all 0",
                     axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_ARVALID, res_valid,
                     axi.M_AXI_BREADY, busy, done_cnt);
        end
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        send_op(32'd4, 32'd4, 1'b0);
        wait_result(lat);
        accept_result();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_stalls();
        test_bresp_err();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge ACLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
